// File: rtl/fifo_pkg.sv
// Shared defaults, width helpers and payload types for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Pointer width: enough bits to address DEPTH entries (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: enough bits to hold the values 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEFAULT_WIDTH-1:0] fifo_word_t;

  // Per-access status reported one cycle after the request.
  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: one write port, one registered read port.
// Storage itself is not reset; only the read-data register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write port; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy flags and per-access status
// (write acknowledge, overflow, underflow). Depth need not be a power of two.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEFAULT_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int unsigned PTR_W = ptr_w(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_status_t     status_q, status_d;

  logic full_c;
  logic empty_c;
  logic wr_ok;
  logic rd_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Occupancy flags decoded from the current count.
  assign full_c      = (count_q == CNT_FULL);
  assign empty_c     = (count_q == '0);
  assign full        = full_c;
  assign empty       = empty_c;
  assign almostfull  = (count_q == CNT_AF);
  assign almostempty = (count_q == CNT_ONE);

  // Accept decisions use the pre-edge flags, so a read at empty or a write
  // at full is rejected even if the other side is accepted in the same cycle.
  always_comb begin
    wr_ok    = wr_en && !full_c;
    rd_ok    = rd_en && !empty_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    status_d = '0;

    if (wr_ok) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (rd_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    status_d.wr_ack    = wr_ok;
    status_d.overflow  = wr_en && full_c;
    status_d.underflow = rd_en && empty_c;
  end

  // Pointer, count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign wr_ack    = status_q.wr_ack;
  assign overflow  = status_q.overflow;
  assign underflow = status_q.underflow;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

endmodule
